// File: rtl/rv32_ahb_arbiter.sv
// Two-requester AHB-Lite master arbiter for the RV32 fetch and load/store ports.
// Pipelined address/data phases; fetch is protected from load/store starvation.
module rv32_ahb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_err,
    input  logic            ls_req,
    input  logic [XLEN-1:0] ls_addr,
    input  logic            ls_write,
    input  logic [2:0]      ls_size,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_err,
    output logic [XLEN-1:0] HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    state_t          r_state;
    state_t          w_next;
    logic            r_dp_owner;
    logic            r_hold;
    logic            r_hold_owner;
    logic [3:0]      r_starve_cnt;
    logic [XLEN-1:0] r_hwdata;

    logic w_active;
    logic w_owner;
    logic w_err1;
    logic w_accept;
    logic w_done;
    logic w_is_ls;

    always_comb begin
        w_err1   = (r_state == S_DATA) && HRESP && !HREADY;
        w_active = 1'b0;
        w_owner  = OWN_IF;
        if (r_hold) begin
            w_active = 1'b1;
            w_owner  = r_hold_owner;
        end else if (if_req && ls_req) begin
            w_active = 1'b1;
            w_owner  = (r_starve_cnt == 4'(STARVE_LIMIT)) ? OWN_IF : OWN_LS;
        end else if (ls_req) begin
            w_active = 1'b1;
            w_owner  = OWN_LS;
        end else if (if_req) begin
            w_active = 1'b1;
            w_owner  = OWN_IF;
        end
        // First error cycle cancels whatever address phase would be presented
        if (w_err1 || !rst_n) begin
            w_active = 1'b0;
        end
    end

    assign w_is_ls  = w_active && (w_owner == OWN_LS);
    assign w_accept = w_active && HREADY;

    assign HTRANS = w_active ? 2'b10 : 2'b00;
    assign HADDR  = !w_active ? '0 : (w_is_ls ? ls_addr : if_addr);
    assign HWRITE = w_is_ls && ls_write;
    assign HSIZE  = w_is_ls ? ls_size : 3'b010;
    assign HPROT  = (w_active && !w_is_ls) ? 4'b0010 : 4'b0011;
    assign HBURST = 3'b000;
    assign HWDATA = r_hwdata;

    assign if_gnt = w_accept && (w_owner == OWN_IF);
    assign ls_gnt = w_accept && (w_owner == OWN_LS);

    assign w_done = rst_n && HREADY &&
                    ((r_state == S_DATA) || (r_state == S_ERR));

    assign if_rvalid = w_done && (r_dp_owner == OWN_IF);
    assign ls_rvalid = w_done && (r_dp_owner == OWN_LS);
    assign if_err    = if_rvalid && (r_state == S_ERR);
    assign ls_err    = ls_rvalid && (r_state == S_ERR);
    assign if_rdata  = HRDATA;
    assign ls_rdata  = HRDATA;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_DATA;
            end
            S_DATA: begin
                if (w_err1) w_next = S_ERR;
                else if (HREADY) w_next = w_accept ? S_DATA : S_IDLE;
            end
            S_ERR: begin
                if (HREADY) w_next = w_accept ? S_DATA : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_dp_owner   <= OWN_IF;
            r_hold       <= 1'b0;
            r_hold_owner <= OWN_IF;
            r_starve_cnt <= '0;
            r_hwdata     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_dp_owner <= w_owner;
            if (w_err1) begin
                r_hold <= 1'b0;
            end else if (w_active && !HREADY) begin
                r_hold       <= 1'b1;
                r_hold_owner <= w_owner;
            end else if (HREADY) begin
                r_hold <= 1'b0;
            end
            if (ls_gnt && ls_write) r_hwdata <= ls_wdata;
            if (!if_req || if_gnt) begin
                r_starve_cnt <= '0;
            end else if (ls_gnt && (r_starve_cnt < 4'(STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_rv32_ahb_arbiter.sv
// Directed testbench for rv32_ahb_arbiter; the bench acts as the AHB slave.
module tb_rv32_ahb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic [31:0] ls_addr;
    logic        ls_write;
    logic [2:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int checks   = 0;
    int failures = 0;

    rv32_ahb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_write(ls_write),
        .ls_size(ls_size), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        if_addr = '0; ls_addr = '0; ls_write = 1'b0; ls_size = 3'b010;
        ls_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        cyc(); cyc(); settle();
        checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL rst_htrans got=%b exp=00", HTRANS); end
        checks++; if (HADDR !== 32'h0) begin failures++; $display("FAIL rst_haddr got=%h exp=0", HADDR); end
        checks++; if (HSIZE !== 3'b010) begin failures++; $display("FAIL rst_hsize got=%b exp=010", HSIZE); end
        checks++; if (HWRITE !== 1'b0) begin failures++; $display("FAIL rst_hwrite got=%b exp=0", HWRITE); end
        checks++; if (HWDATA !== 32'h0) begin failures++; $display("FAIL rst_hwdata got=%h exp=0", HWDATA); end
        checks++; if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err} !== 6'b0) begin failures++; $display("FAIL rst_flags got=%b exp=000000", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err}); end
        checks++; if (HBURST !== 3'b000) begin failures++; $display("FAIL rst_hburst got=%b exp=000", HBURST); end
        checks++; if (HPROT !== 4'b0011) begin failures++; $display("FAIL rst_hprot got=%b exp=0011", HPROT); end
        checks++; if (dut.r_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dut.r_state); end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_if_stream();
        for (int k = 0; k < 4; k++) begin
            cyc();
            if_req  = (k < 3);
            if_addr = 32'(4 * k);
            HRDATA  = 32'hA000_0000 + 32'(4 * (k - 1));
            settle();
            if (k < 3) begin
                checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL ifs_gnt%0d got=%b exp=1", k, if_gnt); end
                checks++; if (HTRANS !== 2'b10) begin failures++; $display("FAIL ifs_htrans%0d got=%b exp=10", k, HTRANS); end
                checks++; if (HADDR !== 32'(4 * k)) begin failures++; $display("FAIL ifs_haddr%0d got=%h exp=%h", k, HADDR, 4 * k); end
                checks++; if (HPROT !== 4'b0010) begin failures++; $display("FAIL ifs_hprot%0d got=%b exp=0010", k, HPROT); end
            end else begin
                checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL ifs_idle got=%b exp=00", HTRANS); end
            end
            checks++; if (if_rvalid !== (k > 0)) begin failures++; $display("FAIL ifs_rvalid%0d got=%b exp=%b", k, if_rvalid, k > 0); end
            if (k > 0) begin
                checks++; if (if_rdata !== 32'hA000_0000 + 32'(4 * (k - 1))) begin failures++; $display("FAIL ifs_rdata%0d got=%h exp=%h", k, if_rdata, 32'hA000_0000 + 32'(4 * (k - 1))); end
            end
        end
        cyc();
        settle();
        checks++; if (if_rvalid !== 1'b0) begin failures++; $display("FAIL ifs_tail_rvalid got=%b exp=0", if_rvalid); end
    endtask

    task automatic test_contention();
        logic [4:0] exp_ls;
        exp_ls = 5'b01111;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if_req = 1'b1; if_addr = 32'h40;
            ls_req = 1'b1; ls_addr = 32'h200; ls_write = 1'b0; ls_size = 3'b010;
            settle();
            checks++; if ({ls_gnt, if_gnt} !== {exp_ls[k], ~exp_ls[k]}) begin failures++; $display("FAIL cont_gnt%0d got ls=%b if=%b exp ls=%b", k, ls_gnt, if_gnt, exp_ls[k]); end
        end
        cyc();
        checks++; if (dut.r_starve_cnt !== 4'd0) begin failures++; $display("FAIL cont_starve got=%0d exp=0", dut.r_starve_cnt); end
        if_req = 1'b0; ls_req = 1'b0;
        settle();
        checks++; if ({if_rvalid, ls_rvalid} !== 2'b10) begin failures++; $display("FAIL cont_last_rvalid got=%b exp=10", {if_rvalid, ls_rvalid}); end
        cyc();
    endtask

    task automatic test_store_wait();
        for (int k = 0; k < 3; k++) begin
            cyc();
            ls_req = 1'b1; ls_addr = 32'h100; ls_write = 1'b1;
            ls_size = 3'b010; ls_wdata = 32'hDEAD_BEEF;
            HREADY = (k == 2);
            settle();
            checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h100 || HWRITE !== 1'b1) begin failures++; $display("FAIL st_addr%0d got=%b/%h/%b exp=10/100/1", k, HTRANS, HADDR, HWRITE); end
            checks++; if (ls_gnt !== (k == 2)) begin failures++; $display("FAIL st_gnt%0d got=%b exp=%b", k, ls_gnt, k == 2); end
        end
        cyc();
        ls_req = 1'b0; ls_wdata = 32'h0; HREADY = 1'b0;
        settle();
        checks++; if (HWDATA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL st_hwdata_w got=%h exp=deadbeef", HWDATA); end
        checks++; if (ls_rvalid !== 1'b0) begin failures++; $display("FAIL st_rvalid_w got=%b exp=0", ls_rvalid); end
        cyc();
        HREADY = 1'b1;
        settle();
        checks++; if (HWDATA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL st_hwdata got=%h exp=deadbeef", HWDATA); end
        checks++; if (ls_rvalid !== 1'b1 || ls_gnt !== 1'b0) begin failures++; $display("FAIL st_done got rv=%b gnt=%b exp rv=1 gnt=0", ls_rvalid, ls_gnt); end
        cyc();
    endtask

    task automatic test_error();
        cyc();
        ls_req = 1'b1; ls_addr = 32'h4000_0000; ls_write = 1'b0; ls_size = 3'b010;
        settle();
        checks++; if (ls_gnt !== 1'b1) begin failures++; $display("FAIL err_gnt got=%b exp=1", ls_gnt); end
        cyc();
        ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h80;
        HRESP = 1'b1; HREADY = 1'b0;
        settle();
        checks++; if (HTRANS !== 2'b00 || if_gnt !== 1'b0) begin failures++; $display("FAIL err_c1 got htrans=%b ifgnt=%b exp 00/0", HTRANS, if_gnt); end
        checks++; if (ls_rvalid !== 1'b0) begin failures++; $display("FAIL err_c1_rvalid got=%b exp=0", ls_rvalid); end
        cyc();
        HREADY = 1'b1;
        settle();
        checks++; if (ls_rvalid !== 1'b1 || ls_err !== 1'b1) begin failures++; $display("FAIL err_c2 got rv=%b err=%b exp 1/1", ls_rvalid, ls_err); end
        checks++; if (if_gnt !== 1'b1 || HADDR !== 32'h80) begin failures++; $display("FAIL err_regrant got gnt=%b addr=%h exp 1/80", if_gnt, HADDR); end
        cyc();
        HRESP = 1'b0; if_req = 1'b0; HRDATA = 32'h1234_5678;
        settle();
        checks++; if (if_rvalid !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'h1234_5678) begin failures++; $display("FAIL err_if_done got rv=%b err=%b d=%h exp 1/0/12345678", if_rvalid, if_err, if_rdata); end
        checks++; if (ls_rvalid !== 1'b0) begin failures++; $display("FAIL err_ls_once got=%b exp=0", ls_rvalid); end
        cyc();
    endtask

    task automatic test_reset_mid();
        cyc();
        ls_req = 1'b1; ls_addr = 32'h300; ls_write = 1'b0; ls_size = 3'b010;
        settle();
        checks++; if (ls_gnt !== 1'b1) begin failures++; $display("FAIL rm_gnt got=%b exp=1", ls_gnt); end
        cyc();
        ls_req = 1'b0; HREADY = 1'b0; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; HREADY = 1'b1;
        settle();
        checks++; if (HTRANS !== 2'b00 || ls_rvalid !== 1'b0) begin failures++; $display("FAIL rm_after got htrans=%b rv=%b exp 00/0", HTRANS, ls_rvalid); end
        checks++; if (dut.r_state !== 2'd0) begin failures++; $display("FAIL rm_state got=%0d exp=0", dut.r_state); end
        cyc();
        if_req = 1'b1; if_addr = 32'h10;
        settle();
        checks++; if (if_gnt !== 1'b1 || HADDR !== 32'h10) begin failures++; $display("FAIL rm_regrant got gnt=%b addr=%h exp 1/10", if_gnt, HADDR); end
        cyc();
        if_req = 1'b0; HRDATA = 32'hCAFE_0010;
        settle();
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hCAFE_0010) begin failures++; $display("FAIL rm_rvalid got rv=%b d=%h exp 1/cafe0010", if_rvalid, if_rdata); end
        cyc();
    endtask

    task automatic test_byte_load();
        cyc();
        ls_req = 1'b1; ls_addr = 32'h103; ls_write = 1'b0; ls_size = 3'b000;
        settle();
        checks++; if (HSIZE !== 3'b000 || HADDR !== 32'h103 || HPROT !== 4'b0011) begin failures++; $display("FAIL bl_ctrl got size=%b addr=%h prot=%b exp 000/103/0011", HSIZE, HADDR, HPROT); end
        checks++; if (ls_gnt !== 1'b1 || HWRITE !== 1'b0) begin failures++; $display("FAIL bl_gnt got gnt=%b wr=%b exp 1/0", ls_gnt, HWRITE); end
        cyc();
        ls_req = 1'b0; HRDATA = 32'h1122_3344;
        settle();
        checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h1122_3344) begin failures++; $display("FAIL bl_rdata got rv=%b d=%h exp 1/11223344", ls_rvalid, ls_rdata); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_if_stream();
        test_contention();
        test_store_wait();
        test_error();
        test_reset_mid();
        test_byte_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
